// File: rtl/bit_length_scan_pkg.sv
// Shared definitions for the multi-cycle bit-length/bit-statistics unit:
// result-mode and FSM state encodings plus an index-width helper.
package bit_length_scan_pkg;

  typedef enum logic [1:0] {
    MODE_LEN = 2'd0,
    MODE_LZC = 2'd1,
    MODE_TZC = 2'd2,
    MODE_POP = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width for n positions, never below one bit so n=1 still yields a legal vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_length_scan_chunk_scan.sv
// Combinational per-chunk statistics: any-one flag, highest and lowest set
// bit index, and population count of a CHUNK-bit slice.
module chunk_scan
  import bit_length_scan_pkg::*;
#(
  parameter  int unsigned CHUNK  = 16,
  localparam int unsigned IDX_W  = idx_w(CHUNK),
  localparam int unsigned ONES_W = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0]  chunk,
  output logic              has_one,
  output logic [IDX_W-1:0]  hi_idx,
  output logic [IDX_W-1:0]  lo_idx,
  output logic [ONES_W-1:0] ones
);

  always_comb begin
    has_one = |chunk;
    hi_idx  = '0;
    lo_idx  = '0;
    ones    = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        hi_idx = IDX_W'(i);
        ones   = ones + ONES_W'(1);
      end
    end
    for (int unsigned i = CHUNK; i > 0; i--) begin
      if (chunk[i-1]) lo_idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/bit_length_scan.sv
// Multi-cycle bit-length unit: scans a WIDTH-bit operand CHUNK bits per cycle and
// returns length, leading-zero count, trailing-zero count or popcount with md_end.
module bit_length_scan
  import bit_length_scan_pkg::*;
#(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned CHUNK = 16,
  localparam int unsigned LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] num_in,
  output logic [LEN_W-1:0] len_out,
  output logic             md_end,
  output logic             busy,
  output logic             zero_out
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = idx_w(NCHUNK);
  localparam int unsigned IDX_W  = idx_w(CHUNK);
  localparam int unsigned ONES_W = $clog2(CHUNK + 1);

  state_e             r_state, w_state_nxt;
  mode_e              r_mode;
  logic [WIDTH-1:0]   r_num;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_acc, w_acc_nxt;
  logic               r_found, w_found_nxt;
  logic               r_any;
  logic [LEN_W-1:0]   r_len;
  logic               r_md_end, r_busy, r_zero;

  logic               w_accept, w_last, w_top_down;
  logic [CNT_W-1:0]   w_k;
  logic [CHUNK-1:0]   w_chunk;
  logic               w_has_one;
  logic [IDX_W-1:0]   w_hi, w_lo;
  logic [ONES_W-1:0]  w_ones;
  logic [LEN_W-1:0]   w_base;

  assign len_out  = r_len;
  assign md_end   = r_md_end;
  assign busy     = r_busy;
  assign zero_out = r_zero;

  assign w_top_down = (r_mode == MODE_LEN) || (r_mode == MODE_LZC);
  assign w_k        = w_top_down ? (CNT_W'(NCHUNK - 1) - r_cnt) : r_cnt;
  assign w_chunk    = r_num[w_k*CHUNK +: CHUNK];
  assign w_base     = LEN_W'(w_k) * LEN_W'(CHUNK);
  assign w_last     = (r_cnt == CNT_W'(NCHUNK - 1));

  chunk_scan #(.CHUNK(CHUNK)) u_chunk_scan (
    .chunk   (w_chunk),
    .has_one (w_has_one),
    .hi_idx  (w_hi),
    .lo_idx  (w_lo),
    .ones    (w_ones)
  );

  // Results are registered out of DONE, so md_end lands in the first IDLE cycle;
  // accepts are held off during that cycle to keep the next accept one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: if (md_start && !r_md_end) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_SCAN;
      end
      ST_SCAN: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_acc_nxt   = r_acc;
    w_found_nxt = r_found;
    case (r_mode)
      MODE_LEN: if (!r_found && w_has_one) begin
        w_acc_nxt   = w_base + LEN_W'(w_hi) + LEN_W'(1);
        w_found_nxt = 1'b1;
      end
      MODE_LZC: if (!r_found) begin
        if (w_has_one) begin
          w_acc_nxt   = r_acc + LEN_W'(CHUNK - 1) - LEN_W'(w_hi);
          w_found_nxt = 1'b1;
        end else begin
          w_acc_nxt = r_acc + LEN_W'(CHUNK);
        end
      end
      MODE_TZC: if (!r_found) begin
        if (w_has_one) begin
          w_acc_nxt   = r_acc + LEN_W'(w_lo);
          w_found_nxt = 1'b1;
        end else begin
          w_acc_nxt = r_acc + LEN_W'(CHUNK);
        end
      end
      MODE_POP: w_acc_nxt = r_acc + LEN_W'(w_ones);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= MODE_LEN;
      r_num    <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_found  <= 1'b0;
      r_any    <= 1'b0;
      r_len    <= '0;
      r_md_end <= 1'b0;
      r_busy   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_md_end <= 1'b0;
      if (r_md_end) r_busy <= 1'b0;
      if (w_accept) begin
        r_num   <= num_in;
        r_mode  <= mode_e'(mode);
        r_cnt   <= '0;
        r_acc   <= '0;
        r_found <= 1'b0;
        r_any   <= 1'b0;
        r_busy  <= 1'b1;
      end
      if (r_state == ST_SCAN) begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_acc   <= w_acc_nxt;
        r_found <= w_found_nxt;
        r_any   <= r_any | w_has_one;
      end
      if (r_state == ST_DONE) begin
        r_len    <= r_acc;
        r_zero   <= ~r_any;
        r_md_end <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_length_scan.sv
// Directed bench for bit_length_scan: default 64/16 build plus 64/64, 64/1 and 32/8
// builds sharing the stimulus, checked against hand values and a bitwise model.
module tb_bit_length_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [1:0]  mode;
  logic [63:0] num_in;

  logic [6:0] len_out, len_c64, len_c1;
  logic [5:0] len_w32;
  logic       md_end, busy, zero_out;
  logic       end_c64, busy_c64, zero_c64;
  logic       end_c1, busy_c1, zero_c1;
  logic       end_w32, busy_w32, zero_w32;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bit_length_scan #(.WIDTH(64), .CHUNK(16)) u_dut (
    .clk(clk), .rst(rst), .md_start(md_start), .mode(mode), .num_in(num_in),
    .len_out(len_out), .md_end(md_end), .busy(busy), .zero_out(zero_out));

  bit_length_scan #(.WIDTH(64), .CHUNK(64)) u_c64 (
    .clk(clk), .rst(rst), .md_start(md_start), .mode(mode), .num_in(num_in),
    .len_out(len_c64), .md_end(end_c64), .busy(busy_c64), .zero_out(zero_c64));

  bit_length_scan #(.WIDTH(64), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .md_start(md_start), .mode(mode), .num_in(num_in),
    .len_out(len_c1), .md_end(end_c1), .busy(busy_c1), .zero_out(zero_c1));

  bit_length_scan #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .rst(rst), .md_start(md_start), .mode(mode), .num_in(num_in[31:0]),
    .len_out(len_w32), .md_end(end_w32), .busy(busy_w32), .zero_out(zero_w32));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_model(input int w, input logic [63:0] x, input logic [1:0] m);
    int msb = -1;
    int lsb = -1;
    int pop = 0;
    for (int i = 0; i < w; i++) begin
      if (x[i]) begin
        pop++;
        msb = i;
        if (lsb < 0) lsb = i;
      end
    end
    case (m)
      2'd0:    return msb + 1;
      2'd1:    return w - 1 - msb;
      2'd2:    return (lsb < 0) ? w : lsb;
      default: return pop;
    endcase
  endfunction

  // Single run on the 64/16 build with hand-computed result and 5-cycle latency.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [63:0] x,
                        input int exp_len, input logic exp_zero);
    int lat = 0;
    mode = m; num_in = x; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    chk({tag, ".busy_on"}, busy, 1);
    while (!md_end && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, lat, 5);
    chk({tag, ".len"}, len_out, exp_len);
    chk({tag, ".zero"}, zero_out, exp_zero);
    tick();
    chk({tag, ".pulse"}, md_end, 0);
    chk({tag, ".busy_off"}, busy, 0);
  endtask

  // One accept seen by all four builds; each is checked against the model and its own latency.
  task automatic run_multi(input logic [1:0] m, input logic [63:0] x);
    bit s0 = 0, s1 = 0, s2 = 0, s3 = 0;
    mode = m; num_in = x; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    for (int c = 1; c <= 80 && !(s0 && s1 && s2 && s3); c++) begin
      tick();
      if (!s0 && md_end) begin
        s0 = 1;
        chk("m16.lat", c, 5);
        chk("m16.len", len_out, ref_model(64, x, m));
        chk("m16.zero", zero_out, (x == 64'd0));
      end
      if (!s1 && end_c64) begin
        s1 = 1;
        chk("c64.lat", c, 2);
        chk("c64.len", len_c64, ref_model(64, x, m));
        chk("c64.zero", zero_c64, (x == 64'd0));
      end
      if (!s2 && end_c1) begin
        s2 = 1;
        chk("c1.lat", c, 65);
        chk("c1.len", len_c1, ref_model(64, x, m));
        chk("c1.zero", zero_c1, (x == 64'd0));
      end
      if (!s3 && end_w32) begin
        s3 = 1;
        chk("w32.lat", c, 5);
        chk("w32.len", len_w32, ref_model(32, x, m));
        chk("w32.zero", zero_w32, (x[31:0] == 32'd0));
      end
    end
    if (!s0) chk("m16.timeout", 0, 1);
    if (!s1) chk("c64.timeout", 0, 1);
    if (!s2) chk("c1.timeout", 0, 1);
    if (!s3) chk("w32.timeout", 0, 1);
    tick();
  endtask

  initial begin
    int ends;
    rst = 1'b1; md_start = 1'b0; mode = 2'd0; num_in = '0;
    tick();
    tick();
    chk("rst.len", len_out, 0);
    chk("rst.md_end", md_end, 0);
    chk("rst.busy", busy, 0);
    chk("rst.zero", zero_out, 0);
    rst = 1'b0;
    tick();

    run_op("len9", 2'd0, 64'h9, 4, 1'b0);

    run_op("z.len", 2'd0, 64'h0, 0, 1'b1);
    run_op("z.lzc", 2'd1, 64'h0, 64, 1'b1);
    run_op("z.tzc", 2'd2, 64'h0, 64, 1'b1);
    run_op("z.pop", 2'd3, 64'h0, 0, 1'b1);

    run_op("e.len", 2'd0, 64'h8000_0000_0000_0001, 64, 1'b0);
    run_op("e.lzc", 2'd1, 64'h8000_0000_0000_0001, 0, 1'b0);
    run_op("e.tzc", 2'd2, 64'h8000_0000_0000_0001, 0, 1'b0);
    run_op("e.pop", 2'd3, 64'h8000_0000_0000_0001, 2, 1'b0);
    run_op("b40.tzc", 2'd2, 64'h0000_0100_0000_0000, 40, 1'b0);
    run_op("b40.lzc", 2'd1, 64'h0000_0100_0000_0000, 23, 1'b0);
    run_op("b40.len", 2'd0, 64'h0000_0100_0000_0000, 41, 1'b0);

    // md_start held high throughout with a changing operand
    mode = 2'd3; num_in = 64'h0000_0000_0000_00FF; md_start = 1'b1;
    tick();
    ends = 0;
    for (int i = 0; i < 5; i++) begin
      num_in = 64'hFFFF_FFFF_0000_0000 >> i;
      tick();
      if (md_end) ends++;
    end
    chk("hold.ends", ends, 1);
    chk("hold.md_end", md_end, 1);
    chk("hold.len", len_out, 8);
    num_in = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("hold.gap_md_end", md_end, 0);
    chk("hold.gap_busy", busy, 0);
    num_in = 64'h0000_0000_000F_F000;
    tick();
    chk("hold.reaccept", busy, 1);
    md_start = 1'b0;
    ends = 0;
    while (!md_end && ends < 20) begin
      tick();
      ends++;
    end
    chk("hold.lat2", ends, 5);
    chk("hold.len2", len_out, 8);

    // reset in the second SCAN cycle discards the run
    mode = 2'd0; num_in = 64'h1_0000; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.len", len_out, 0);
    chk("mrst.md_end", md_end, 0);
    chk("mrst.busy", busy, 0);
    chk("mrst.zero", zero_out, 0);
    ends = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (md_end) ends++;
    end
    chk("mrst.no_end", ends, 0);
    run_op("mrst.after", 2'd0, 64'h1_0000, 17, 1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_multi(2'd0, 64'h0000_0000_8000_0000);
    run_multi(2'd1, 64'h0);
    run_multi(2'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_multi(2'd3, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] rv;
      rv = {$urandom, $urandom} >> $urandom_range(0, 40);
      run_multi(2'($urandom_range(0, 3)), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
